// File: rtl/cmp_rf_pkg.sv
// Shared register-file types and constants: write-request record, partial-write codes.
package cmp_rf_pkg;

   localparam int REG_IDX_W = 5;
   localparam int DATA_W    = 64;
   localparam int PPP_W     = 3;
   localparam int NUM_REGS  = 32;

   // Bit 0 is the MSB of the 64-bit word; "HI" selects [0:31], "LO" selects [32:63].
   localparam logic [0:PPP_W-1] PPP_FULL = 3'b000;
   localparam logic [0:PPP_W-1] PPP_HI   = 3'b001;
   localparam logic [0:PPP_W-1] PPP_LO   = 3'b010;
   localparam logic [0:PPP_W-1] PPP_EVEN = 3'b011;
   localparam logic [0:PPP_W-1] PPP_ODD  = 3'b100;

   typedef struct packed {
      logic [0:REG_IDX_W-1] rd;
      logic [0:PPP_W-1]     ppp;
      logic [0:DATA_W-1]    data;
   } rf_wr_req_t;

endpackage

// File: rtl/rf_nic_fifo.sv
// Power-of-two FIFO holding load-return write requests until the RF port is free.
module rf_nic_fifo
   import cmp_rf_pkg::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  rf_wr_req_t               i_data,
   input  logic                     i_pop,
   output rf_wr_req_t               o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   rf_wr_req_t r_mem [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        w_push;
   logic        w_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign o_count = r_wr_ptr - r_rd_ptr;
   assign o_full  = (o_count == (AW+1)'(DEPTH));
   assign o_empty = (o_count == '0);
   assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

   // A full FIFO refuses a push even when it pops in the same cycle.
   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/rf_wr_sched.sv
// RF write-port scheduler: WB has priority, buffered load returns fill idle slots,
// a starvation timer forces a load-return write, and a scoreboard flags pending loads.
module rf_wr_sched
   import cmp_rf_pkg::*;
#(
   parameter int NIC_DEPTH  = 2,
   parameter int STARVE_MAX = 4
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wb_wrEn,
   input  logic [0:REG_IDX_W-1]   wb_rD,
   input  logic [0:PPP_W-1]       wb_ppp,
   input  logic [0:DATA_W-1]      wb_data,
   input  logic                   nic_valid,
   output logic                   nic_ready,
   input  logic [0:REG_IDX_W-1]   nic_rD,
   input  logic [0:PPP_W-1]       nic_ppp,
   input  logic [0:DATA_W-1]      nic_data,
   input  logic                   lock_en,
   input  logic [0:REG_IDX_W-1]   lock_rD,
   input  logic [0:REG_IDX_W-1]   rA,
   input  logic [0:REG_IDX_W-1]   rB,
   output logic                   hazard_A,
   output logic                   hazard_B,
   output logic                   stall_wb,
   output logic                   rf_wrEn,
   output logic [0:REG_IDX_W-1]   rf_rD,
   output logic [0:PPP_W-1]       rf_ppp,
   output logic [0:DATA_W-1]      rf_data
);

   localparam int              CNT_W       = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
   localparam logic [CNT_W-1:0] STARVE_LOAD = CNT_W'(STARVE_MAX - 1);

   rf_wr_req_t                  w_nic_req;
   rf_wr_req_t                  w_head;
   logic                        w_push;
   logic                        w_full;
   logic                        w_empty;
   logic [$clog2(NIC_DEPTH):0]  w_count;
   logic                        w_wb_win;
   logic                        w_nic_win;
   logic                        r_stall_wb;
   logic [CNT_W-1:0]            r_starve_left;
   logic [NUM_REGS-1:0]         r_busy;
   logic [NUM_REGS-1:0]         w_busy_nxt;

   assign w_nic_req = '{rd: nic_rD, ppp: nic_ppp, data: nic_data};
   assign w_push    = nic_valid && !w_full;
   assign nic_ready = !w_full;
   assign stall_wb  = r_stall_wb;

   rf_nic_fifo #(
      .DEPTH   (NIC_DEPTH)
   ) u_nic_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_push),
      .i_data  (w_nic_req),
      .i_pop   (w_nic_win),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_comb begin
      w_wb_win  = wb_wrEn && !r_stall_wb;
      w_nic_win = !w_wb_win && !w_empty;
      rf_wrEn   = 1'b0;
      rf_rD     = '0;
      rf_ppp    = '0;
      rf_data   = '0;
      if (w_wb_win) begin
         rf_wrEn = 1'b1;
         rf_rD   = wb_rD;
         rf_ppp  = wb_ppp;
         rf_data = wb_data;
      end else if (w_nic_win) begin
         rf_wrEn = 1'b1;
         rf_rD   = w_head.rd;
         rf_ppp  = w_head.ppp;
         rf_data = w_head.data;
      end
   end

   // Down-counter of remaining head wait; at terminal count with no pop, WB is held for one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_starve_left <= STARVE_LOAD;
         r_stall_wb    <= 1'b0;
      end else begin
         r_stall_wb <= !w_empty && !w_nic_win && (r_starve_left == '0);
         if (w_empty || w_nic_win) begin
            r_starve_left <= STARVE_LOAD;
         end else if (r_starve_left != '0) begin
            r_starve_left <= r_starve_left - 1'b1;
         end
      end
   end

   // A same-cycle lock of the committing register must survive the commit.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_nic_win) w_busy_nxt[w_head.rd] = 1'b0;
      if (lock_en && (lock_rD != '0)) w_busy_nxt[lock_rD] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   // A commit in this cycle reaches decode through the RF write-through path.
   assign hazard_A = r_busy[rA] && !(w_nic_win && (w_head.rd == rA));
   assign hazard_B = r_busy[rB] && !(w_nic_win && (w_head.rd == rB));

   a_count_empty: assert property (@(posedge clk) disable iff (!reset)
      w_empty == (w_count == '0));

endmodule

// File: tb/tb_rf_wr_sched.sv
// Bench for rf_wr_sched: queue/array reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic with occasional mid-run resets.
module tb_rf_wr_sched;
   import cmp_rf_pkg::*;

   localparam int DEPTH = 2;
   localparam int SMAX  = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_wrEn;
   logic [0:4]  wb_rD;
   logic [0:2]  wb_ppp;
   logic [0:63] wb_data;
   logic        nic_valid;
   logic        nic_ready;
   logic [0:4]  nic_rD;
   logic [0:2]  nic_ppp;
   logic [0:63] nic_data;
   logic        lock_en;
   logic [0:4]  lock_rD;
   logic [0:4]  rA;
   logic [0:4]  rB;
   logic        hazard_A;
   logic        hazard_B;
   logic        stall_wb;
   logic        rf_wrEn;
   logic [0:4]  rf_rD;
   logic [0:2]  rf_ppp;
   logic [0:63] rf_data;

   always #5 clk = ~clk;

   rf_wr_sched #(.NIC_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .reset(reset),
      .wb_wrEn(wb_wrEn), .wb_rD(wb_rD), .wb_ppp(wb_ppp), .wb_data(wb_data),
      .nic_valid(nic_valid), .nic_ready(nic_ready), .nic_rD(nic_rD),
      .nic_ppp(nic_ppp), .nic_data(nic_data),
      .lock_en(lock_en), .lock_rD(lock_rD), .rA(rA), .rB(rB),
      .hazard_A(hazard_A), .hazard_B(hazard_B), .stall_wb(stall_wb),
      .rf_wrEn(rf_wrEn), .rf_rD(rf_rD), .rf_ppp(rf_ppp), .rf_data(rf_data)
   );

   typedef struct {
      logic [0:4]  rd;
      logic [0:2]  ppp;
      logic [0:63] data;
   } ent_t;

   ent_t        m_q[$];
   bit          m_busy[32];
   int          m_wait;
   bit          m_stall;
   bit          m_wb_stalled;
   logic [0:63] m_rf[32];

   logic        s_ready, s_wr, s_hA, s_hB, s_stall;
   logic [0:4]  s_rd;
   logic [0:63] s_data;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [0:63] merge(input logic [0:63] old, input logic [0:63] nw,
                                         input logic [0:2] p);
      logic [0:63] r;
      r = old;
      case (p)
         PPP_FULL: r = nw;
         PPP_HI:   r[0:31] = nw[0:31];
         PPP_LO:   r[32:63] = nw[32:63];
         PPP_EVEN: for (int b = 0; b < 8; b += 2) r[b*8 +: 8] = nw[b*8 +: 8];
         PPP_ODD:  for (int b = 1; b < 8; b += 2) r[b*8 +: 8] = nw[b*8 +: 8];
         default:  r = old;
      endcase
      return r;
   endfunction

   // Expected outputs from the current model state, then advance the model across the next edge.
   task automatic model_check();
      bit          wbw, nw, ready_now, ehA, ehB, next_stall;
      int          sz;
      ent_t        h;
      logic        ewr;
      logic [0:4]  erd;
      logic [0:2]  epp;
      logic [0:63] edat;
      s_ready = nic_ready; s_wr = rf_wrEn; s_hA = hazard_A; s_hB = hazard_B;
      s_stall = stall_wb;  s_rd = rf_rD;   s_data = rf_data;
      if (!reset) begin
         m_q.delete();
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
         m_wait  = 0;
         m_stall = 1'b0;
      end
      sz  = m_q.size();
      wbw = wb_wrEn && !m_stall;
      nw  = !wbw && (sz != 0);
      h   = '{rd: 5'd0, ppp: 3'd0, data: 64'd0};
      if (sz != 0) h = m_q[0];
      ewr = 1'b0; erd = '0; epp = '0; edat = '0;
      if (wbw) begin
         ewr = 1'b1; erd = wb_rD; epp = wb_ppp; edat = wb_data;
      end else if (nw) begin
         ewr = 1'b1; erd = h.rd; epp = h.ppp; edat = h.data;
      end
      ready_now = (sz < DEPTH);
      ehA = m_busy[int'(rA)] && !(nw && h.rd == rA);
      ehB = m_busy[int'(rB)] && !(nw && h.rd == rB);
      chk("nic_ready", 64'(nic_ready), 64'(ready_now));
      chk("stall_wb",  64'(stall_wb),  64'(m_stall));
      chk("rf_wrEn",   64'(rf_wrEn),   64'(ewr));
      chk("rf_rD",     64'(rf_rD),     64'(erd));
      chk("rf_ppp",    64'(rf_ppp),    64'(epp));
      chk("rf_data",   64'(rf_data),   64'(edat));
      chk("hazard_A",  64'(hazard_A),  64'(ehA));
      chk("hazard_B",  64'(hazard_B),  64'(ehB));
      m_wb_stalled = m_stall && wb_wrEn;
      if (reset) begin
         if (ewr && erd != 0) m_rf[int'(erd)] = merge(m_rf[int'(erd)], edat, epp);
         if (nw) begin
            m_busy[int'(h.rd)] = 1'b0;
            void'(m_q.pop_front());
         end
         if (lock_en && lock_rD != 0) m_busy[int'(lock_rD)] = 1'b1;
         next_stall = 1'b0;
         if (sz != 0 && !nw) begin
            if (m_wait == SMAX - 1) next_stall = 1'b1;
            m_wait++;
         end else begin
            m_wait = 0;
         end
         m_stall = next_stall;
         if (nic_valid && ready_now) m_q.push_back('{rd: nic_rD, ppp: nic_ppp, data: nic_data});
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_check();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_wrEn = 0; wb_rD = 0; wb_ppp = PPP_FULL; wb_data = 0;
      nic_valid = 0; nic_rD = 0; nic_ppp = PPP_FULL; nic_data = 0;
      lock_en = 0; lock_rD = 0; rA = 0; rB = 0;
   endtask

   logic [0:4] obs[$];
   int         accepted_at;
   int         rst_hold;

   initial begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_wait = 0; m_stall = 0; m_wb_stalled = 0;
      reset = 1'b0;
      idle();
      step();
      step();
      chk("rst_ready", 64'(s_ready), 64'd1);
      chk("rst_wrEn",  64'(s_wr),    64'd0);
      chk("rst_hzA",   64'(s_hA),    64'd0);
      chk("rst_hzB",   64'(s_hB),    64'd0);
      chk("rst_stall", 64'(s_stall), 64'd0);
      reset = 1'b1;
      step();

      // Lock r5, hazard appears the following cycle.
      lock_en = 1; lock_rD = 5; rA = 5;
      step();
      lock_en = 0;
      step();
      chk("lock_hzA", 64'(s_hA), 64'd1);

      // Load return for r5: no bypass, commit next cycle clears the hazard in that cycle.
      nic_valid = 1; nic_rD = 5; nic_ppp = PPP_FULL; nic_data = 64'h0123_4567_89AB_CDEF;
      step();
      chk("nic_nobypass", 64'(s_wr), 64'd0);
      nic_valid = 0;
      step();
      chk("nic_wrEn", 64'(s_wr),   64'd1);
      chk("nic_rD",   64'(s_rd),   64'd5);
      chk("nic_data", 64'(s_data), 64'h0123_4567_89AB_CDEF);
      chk("nic_hzA",  64'(s_hA),   64'd0);
      step();

      // WB and buffered load both target r7.
      wb_wrEn = 1; wb_rD = 3; wb_data = 64'h1111_1111_1111_1111;
      nic_valid = 1; nic_rD = 7; nic_data = 64'h5555_5555_5555_5555;
      step();
      nic_valid = 0; wb_rD = 7; wb_data = 64'hAAAA_AAAA_AAAA_AAAA;
      step();
      chk("conf_wb_rD",   64'(s_rd),   64'd7);
      chk("conf_wb_data", 64'(s_data), 64'hAAAA_AAAA_AAAA_AAAA);
      wb_wrEn = 0;
      step();
      chk("conf_nic_data", 64'(s_data), 64'h5555_5555_5555_5555);
      chk("conf_r7_model", 64'(m_rf[7]), 64'h5555_5555_5555_5555);
      step();

      // Starvation: WB held busy, head forced out five cycles after its push.
      wb_wrEn = 1; wb_rD = 10; wb_data = 64'hC0; nic_valid = 1; nic_rD = 11;
      nic_data = 64'hFEED_0000_0000_0011;
      step();
      nic_valid = 0;
      for (int c = 1; c <= 4; c++) begin
         wb_data = 64'(c);
         step();
         chk("starve_nostall", 64'(s_stall), 64'd0);
      end
      step();
      chk("starve_stall", 64'(s_stall), 64'd1);
      chk("starve_rD",    64'(s_rd),    64'd11);
      chk("starve_data",  64'(s_data),  64'hFEED_0000_0000_0011);
      step();
      chk("starve_clear", 64'(s_stall), 64'd0);
      chk("starve_wb_rD", 64'(s_rd),    64'd10);
      wb_wrEn = 0;
      step();
      step();

      // Full buffer under busy WB: third return held until the first forced pop frees a slot.
      obs.delete();
      accepted_at = -1;
      wb_wrEn = 1; wb_rD = 12;
      for (int k = 0; k < 14; k++) begin
         nic_valid = (accepted_at < 0);
         nic_rD = 5'(20 + ((k < 2) ? k : 2));
         nic_data = 64'(k + 100);
         step();
         if (s_wr && s_rd >= 20) obs.push_back(s_rd);
         if (k == 2) chk("full_ready", 64'(s_ready), 64'd0);
         if (k >= 2 && accepted_at < 0 && s_ready) accepted_at = k;
      end
      chk("full_accept_cycle", 64'(accepted_at), 64'd6);
      nic_valid = 0; wb_wrEn = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (s_wr && s_rd >= 20) obs.push_back(s_rd);
      end
      chk("full_commits", 64'(obs.size()), 64'd3);
      for (int i = 0; i < obs.size() && i < 3; i++) chk("full_order", 64'(obs[i]), 64'(20 + i));

      // Lock and commit of r9 in the same cycle: lock wins.
      lock_en = 1; lock_rD = 9;
      step();
      lock_en = 0; nic_valid = 1; nic_rD = 9; nic_data = 64'h99;
      step();
      nic_valid = 0; lock_en = 1; lock_rD = 9; rB = 9;
      step();
      chk("coll_commit_rD", 64'(s_rd), 64'd9);
      chk("coll_same_hzB",  64'(s_hB), 64'd0);
      lock_en = 0;
      step();
      chk("coll_next_hzB", 64'(s_hB), 64'd1);

      // Randomized traffic against the model.
      rst_hold = 0;
      for (int n = 0; n < 4000; n++) begin
         if (rst_hold > 0) begin
            reset = 1'b0; rst_hold--;
         end else if ($urandom_range(0, 399) == 0) begin
            reset = 1'b0; rst_hold = 1;
         end else begin
            reset = 1'b1;
         end
         if (!(m_wb_stalled && wb_wrEn)) begin
            wb_wrEn = ((n / 200) % 2 == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 4);
            wb_rD   = 5'($urandom_range(0, 31));
            wb_ppp  = 3'($urandom_range(0, 7));
            wb_data = {$urandom, $urandom};
         end
         if (!(nic_valid && !s_ready)) begin
            nic_valid = ($urandom_range(0, 2) == 0);
            nic_rD    = 5'($urandom_range(0, 31));
            nic_ppp   = 3'($urandom_range(0, 7));
            nic_data  = {$urandom, $urandom};
         end
         lock_en = ($urandom_range(0, 3) == 0);
         lock_rD = 5'($urandom_range(0, 31));
         rA      = ($urandom_range(0, 1) == 0) ? nic_rD : 5'($urandom_range(0, 31));
         rB      = 5'($urandom_range(0, 31));
         step();
      end
      reset = 1'b1;
      idle();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rf_wr_sched.md
Name: rf_wr_sched

Overview:
- Write-port scheduler for the 32x64 register file. It shares the single RF write port between two sources:
  - the WB pipeline stage, which has priority and no backpressure;
  - the NIC/memory load-return path, which uses a valid/ready handshake and is buffered.
- Keeps a per-register pending-load scoreboard so decode can detect RAW hazards on outstanding loads.
- Sits between WB/NIC and the RF write inputs (wrEn, rD, ppp, d_in).

Parameters:
- NIC_DEPTH, 2, number of entries in the NIC return buffer (power of 2, minimum 2).
- STARVE_MAX, 4, consecutive cycles the buffer head may wait before WB is stalled.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- wb_wrEn  in  1  WB write request.
- wb_rD  in  [0:4]  WB destination register.
- wb_ppp  in  [0:2]  WB partial-write select.
- wb_data  in  [0:63]  WB write data.
- nic_valid  in  1  NIC return data valid.
- nic_ready  out  1  NIC return accepted this cycle.
- nic_rD  in  [0:4]  NIC return destination.
- nic_ppp  in  [0:2]  NIC partial-write select.
- nic_data  in  [0:63]  NIC return data.
- lock_en  in  1  a load is issued this cycle; mark lock_rD pending.
- lock_rD  in  [0:4]  destination of the issued load.
- rA  in  [0:4]  decode source A query.
- rB  in  [0:4]  decode source B query.
- hazard_A  out  1  rA has a load pending.
- hazard_B  out  1  rB has a load pending.
- stall_wb  out  1  hold the WB stage; WB must re-present the same request next cycle.
- rf_wrEn  out  1  RF write enable.
- rf_rD  out  [0:4]  RF destination.
- rf_ppp  out  [0:2]  RF partial-write select.
- rf_data  out  [0:63]  RF write data.

Behaviour:
- Reset (reset=0, asynchronous):
  - buffer empty, starvation counter 0, scoreboard all 0, stall_wb 0;
  - therefore nic_ready=1, rf_wrEn=0, hazard_A=hazard_B=0.
- NIC buffer:
  - FIFO of {rD, ppp, data}, NIC_DEPTH entries; nic_ready = !full.
  - Push when nic_valid && nic_ready.
  - When full, a push in the same cycle as a pop is refused; nic_ready stays 0 that cycle.
  - Data entering the buffer can reach the RF no earlier than the next cycle; there is no NIC-to-RF bypass.
- Grant (combinational, every cycle):
  - wb_win = wb_wrEn && !stall_wb.
  - nic_win = !wb_win && !empty.
  - rf_* = WB fields if wb_win; buffer head fields if nic_win; otherwise rf_wrEn=0 and the other rf_* outputs are 0.
  - The buffer pops on nic_win.
- Arbitration result:
  - WB and NIC targeting the same register in the same cycle: WB writes; the NIC entry writes later.
  - The NIC value therefore ends up in the RF.
- Starvation:
  - Counter increments each cycle the buffer is non-empty and does not pop; it clears on any pop or when the buffer is empty.
  - stall_wb is registered. It is set for exactly one cycle on the edge where the counter equals STARVE_MAX-1 and no pop occurs.
  - During a stall_wb cycle, wb_wrEn is ignored and the head is guaranteed to write.
  - This bounds the maximum head wait to STARVE_MAX+1 cycles.
- Scoreboard:
  - busy[31:0] register bits.
  - lock_en sets busy[lock_rD].
  - A NIC commit (nic_win) clears busy[head rD].
  - Set and clear of the same register in one cycle: set wins.
  - busy[0] is never set.
- Hazards:
  - hazard_A = busy[rA] && !(nic_win && head_rD==rA); hazard_B is the same for rB.
  - A same-cycle commit is covered by the RF write-through bypass.
- rD = 0:
  - WB and NIC writes are granted and forwarded unchanged; the RF discards them.
  - Buffer and scoreboard accounting proceed as normal.
- ppp is forwarded unchanged. Codes: 000 full, 001 [0:31], 010 [32:63], 011 even bytes, 100 odd bytes; other codes are forwarded and the RF ignores them.
- Reset asserted mid-operation: buffered returns are dropped, busy is cleared, and stall_wb deasserts immediately.

Decomposition:
- Shared package cmp_rf_pkg holds:
  - REG_IDX_W=5, DATA_W=64, PPP_W=3, NUM_REGS=32;
  - PPP_FULL, PPP_HI, PPP_LO, PPP_EVEN, PPP_ODD;
  - the packed RF write-request record {rD, ppp, data}.
- One sub-module, rf_nic_fifo: parameterised-depth FIFO with full/empty and count. The scheduler instantiates it once.

Test Plan:
- Reset: drive reset=0, then release.
  - Expect nic_ready=1, rf_wrEn=0, hazards 0.
  - Then lock_en with lock_rD=5 and rA=5: hazard_A=1 from the next cycle.
- Idle WB, NIC return:
  - Input: nic_valid=1, nic_rD=5, nic_data=64'h0123_4567_89AB_CDEF.
  - Next cycle: rf_wrEn=1, rf_rD=5, data matches, and hazard_A (rA=5) drops in that cycle.
- WB/NIC conflict:
  - Input: WB rD=7, data 64'hAAAA_AAAA_AAAA_AAAA, with a NIC entry rD=7, data 64'h5555_5555_5555_5555 buffered.
  - Expect WB to write first and NIC the next cycle; final RF r7 = 5555...
- Starvation with STARVE_MAX=4:
  - Input: wb_wrEn=1 held continuously with one NIC entry buffered.
  - Expect stall_wb=1 for exactly one cycle, 5 cycles after the push; that cycle rf_* carries the NIC entry; stall_wb=0 after.
- Full buffer:
  - Input: 2 NIC pushes with WB busy.
  - Expect nic_ready=0; a third nic_valid is held until a pop; no entry is lost or duplicated (check against a scoreboard model).
- Lock/commit collision:
  - Input: lock_en with rD=9 in the same cycle the NIC commits rD=9.
  - Expect busy[9] to remain 1 afterwards; hazard_B (rB=9) =1 on the next cycle.
